gouram_trace_serialiser: RTL and testbench
==========================================

# gouram_trace_serialiser

Consumer end of the Gouram trace port: accepts the 128-bit trace records produced by the Gouram tracer, buffers them in a small FIFO, and emits each record as four 32-bit words on a valid/ready stream towards an off-chip sink (UART/stream bridge). The tracer has no back-pressure, so records arriving while the buffer is full are dropped and counted.

## Interface
Parameters:
- FIFO_DEPTH, 4, record FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- trace_valid_i  in  1  trace_data_i holds a new record this cycle.
- trace_data_i  in  128  trace record; bits [127:96] are the most significant word.
- word_valid_o  out  1  word_data_o valid.
- word_data_o  out  32  current output word.
- word_last_o  out  1  current word is the final (4th) word of a record.
- word_ready_i  in  1  sink accepts the word when high together with word_valid_o.
- drop_count_o  out  CNT_WIDTH  records dropped on full FIFO; saturating.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  records currently buffered (excluding the one being serialised).
- busy_o  out  1  high in SEND state.

## Operation
- FIFO: circular buffer, read/write pointers one bit wider than the address; full = MSBs differ and address bits equal; empty = pointers equal.
- Push: trace_valid_i && (!full || pop this cycle). Otherwise, with trace_valid_i high, the record is dropped and drop_count_o increments, holding at 2^CNT_WIDTH-1.
- Pop: occurs when the serialiser loads the head record (see below); pointer advances the same edge.
- Serialiser FSM, states IDLE and SEND; 128-bit shift register and 2-bit beat counter.
  - IDLE: if FIFO non-empty, pop head into shift register, beat=0, go to SEND.
  - SEND: word_data_o = shift[127:96], word_last_o = (beat==3), word_valid_o = 1.
  - Handshake (word_valid_o && word_ready_i) with beat<3: shift left 32, beat+1.
  - Handshake with beat==3: if FIFO non-empty, pop and load next record, beat=0, stay in SEND (no bubble); else go to IDLE.
- No handshake: word_data_o and word_last_o held stable; word_valid_o never drops until accepted.
- word order per record: [127:96], [95:64], [63:32], [31:0].

## Timing
- Reset: word_valid_o=0, word_data_o=0, word_last_o=0, drop_count_o=0, fifo_level_o=0, busy_o=0; FIFO emptied, FSM to IDLE.
- Reset mid-record: partial record and all buffered records discarded; no word_last_o issued; sink sees word_valid_o low the cycle after rst.
- Latency: record with trace_valid_i at cycle N appears as word 0 with word_valid_o high at cycle N+2 when idle and empty (N: write; N+1: IDLE sees non-empty, pops; N+2: SEND).
- fifo_level_o updates the edge after a push/pop; simultaneous push and pop leave it unchanged.
- Back-to-back records with word_ready_i held high: continuous 4-word bursts, word_valid_o never deasserts between records.
- Push to full FIFO in the same cycle as a last-beat handshake with a pop is accepted, not dropped.
- drop_count_o updates the edge after the dropped cycle.

## Test plan
- Single record 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 at cycle 10, ready high -> words 0x01234567, 0x89ABCDEF, 0x00112233, 0x44556677 at cycles 12–15, word_last_o only at 15, IDLE at 16.
- Back-pressure: word_ready_i low for 5 cycles during beat 1 -> word_data_o held at beat-1 value, word_valid_o stays high; resumes without loss.
- Overflow: word_ready_i low, 7 records pushed on consecutive cycles with FIFO_DEPTH=4 -> first serialiser load + 4 buffered, 2 dropped: drop_count_o=2, fifo_level_o=4.
- Full + simultaneous last-beat pop and push -> record accepted, drop_count_o unchanged, fifo_level_o stays 4.
- Saturation with CNT_WIDTH=4: 20 drops -> drop_count_o=15.
- rst asserted during beat 2 with 3 records buffered -> next cycle all outputs 0, level 0; a following record emerges 2 cycles after push starting at beat 0.

Source files
------------

// File: rtl/gouram_trace_serialiser_if.sv
// rtl/gouram_trace_serialiser_if.sv - trace record input and 32-bit word stream bundle
//
// Purpose: groups the tracer-side record input and the sink-side word stream.
// Signals:
//   trace_valid_i / trace_data_i : 128-bit record from the tracer, no back-pressure
//   word_valid_o / word_data_o / word_last_o / word_ready_i : word stream to the sink
// Modports:
//   slave  : the serialiser (consumes records, produces words)
//   master : the environment (produces records, consumes words)
interface gouram_trace_serialiser_if;
    logic         trace_valid_i;
    logic [127:0] trace_data_i;
    logic         word_valid_o;
    logic [31:0]  word_data_o;
    logic         word_last_o;
    logic         word_ready_i;

    modport slave (
        input  trace_valid_i,
        input  trace_data_i,
        input  word_ready_i,
        output word_valid_o,
        output word_data_o,
        output word_last_o
    );

    modport master (
        output trace_valid_i,
        output trace_data_i,
        output word_ready_i,
        input  word_valid_o,
        input  word_data_o,
        input  word_last_o
    );
endinterface

// File: rtl/gouram_trace_serialiser.sv
// rtl/gouram_trace_serialiser.sv - buffers 128-bit trace records and emits them as four 32-bit words
//
// Purpose: record FIFO plus IDLE/SEND serialiser; records arriving on a full
// FIFO (with no pop the same cycle) are dropped and counted.
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   bus (slave)   : trace record input and word stream output
//   drop_count_o  : saturating count of dropped records
//   fifo_level_o  : records buffered, excluding the one being serialised
//   busy_o        : high while in SEND
module gouram_trace_serialiser #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    gouram_trace_serialiser_if.slave     bus,
    output logic [CNT_WIDTH-1:0]         drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic                         busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [127:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [127:0]         r_shift;
    logic [1:0]           r_beat;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_handshake;
    logic w_last_beat;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_last_beat = (r_beat == 2'd3);
    assign w_handshake = (r_state == ST_SEND) && bus.word_ready_i;

    // A pop frees the slot on the same edge, so a full FIFO still accepts
    // a record when the serialiser loads its head in that cycle.
    assign w_push = bus.trace_valid_i && (!w_full || w_pop);
    assign w_drop = bus.trace_valid_i && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_handshake && w_last_beat) begin
                    // Load the next record directly so bursts have no bubble.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.trace_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_beat  <= 2'd0;
        end else if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            r_beat  <= 2'd0;
        end else if (w_handshake && !w_last_beat) begin
            r_shift <= {r_shift[95:0], 32'h0};
            r_beat  <= r_beat + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign bus.word_valid_o = (r_state == ST_SEND);
    assign bus.word_data_o  = r_shift[127:96];
    assign bus.word_last_o  = (r_state == ST_SEND) && w_last_beat;
    assign drop_count_o     = r_drop_count;
    assign fifo_level_o     = r_wr_ptr - r_rd_ptr;
    assign busy_o           = (r_state == ST_SEND);
endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// tb/tb_gouram_trace_serialiser.sv - directed self-checking bench for gouram_trace_serialiser
module tb_gouram_trace_serialiser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gouram_trace_serialiser_if bus();
    gouram_trace_serialiser_if bus_sat();

    logic [15:0] drop_count;
    logic [2:0]  fifo_level;
    logic        busy;
    logic [3:0]  drop_count_sat;
    logic [2:0]  fifo_level_sat;
    logic        busy_sat;

    gouram_trace_serialiser #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .drop_count_o (drop_count),
        .fifo_level_o (fifo_level),
        .busy_o       (busy)
    );

    gouram_trace_serialiser #(.FIFO_DEPTH(4), .CNT_WIDTH(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_sat),
        .drop_count_o (drop_count_sat),
        .fifo_level_o (fifo_level_sat),
        .busy_o       (busy_sat)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] recs [0:8];

    function automatic logic [31:0] wsel(input logic [127:0] r, input int b);
        return r[127-32*b -: 32];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Checks one output word: valid high, data and last as expected.
    task automatic chk_word(input string name, input logic [31:0] exp_d, input logic exp_l);
        n_cmp++;
        if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_d || bus.word_last_o !== exp_l) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     name, bus.word_valid_o, bus.word_data_o, bus.word_last_o, exp_d, exp_l);
        end
    endtask

    task automatic chk_idle(input string name);
        n_cmp++;
        if (bus.word_valid_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b busy=%b, expected valid=0 busy=0",
                     name, bus.word_valid_o, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.word_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, expected 0", bus.word_valid_o);
        end
        n_cmp++;
        if (bus.word_data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h, expected 0", bus.word_data_o);
        end
        n_cmp++;
        if (bus.word_last_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_last: got %b, expected 0", bus.word_last_o);
        end
        n_cmp++;
        if (drop_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_drop: got %0d, expected 0", drop_count);
        end
        n_cmp++;
        if (fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d, expected 0", fifo_level);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_single();
        logic [127:0] r;
        logic [31:0]  exp_w [4];
        r = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        exp_w[0] = 32'h01234567;
        exp_w[1] = 32'h89ABCDEF;
        exp_w[2] = 32'h00112233;
        exp_w[3] = 32'h44556677;
        bus.word_ready_i  = 1'b1;
        bus.trace_valid_i = 1'b1;
        bus.trace_data_i  = r;
        tick();
        bus.trace_valid_i = 1'b0;
        chk_idle("single_latency_gap");
        n_cmp++;
        if (fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL single_level_after_push: got %0d, expected 1", fifo_level);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_word($sformatf("single_word%0d", i), exp_w[i], i == 3);
            tick();
        end
        chk_idle("single_back_to_idle");
    endtask

    task automatic test_backpressure();
        bus.word_ready_i  = 1'b1;
        bus.trace_valid_i = 1'b1;
        bus.trace_data_i  = recs[0];
        tick();
        bus.trace_valid_i = 1'b0;
        tick();
        chk_word("bp_word0", wsel(recs[0], 0), 1'b0);
        tick();
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_word($sformatf("bp_hold%0d", i), wsel(recs[0], 1), 1'b0);
            tick();
        end
        bus.word_ready_i = 1'b1;
        for (int b = 1; b < 4; b++) begin
            chk_word($sformatf("bp_resume%0d", b), wsel(recs[0], b), b == 3);
            tick();
        end
        chk_idle("bp_idle");
    endtask

    task automatic test_overflow();
        bus.word_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.trace_valid_i = 1'b1;
            bus.trace_data_i  = recs[k];
            tick();
        end
        bus.trace_valid_i = 1'b0;
        n_cmp++;
        if (drop_count !== 16'd2) begin
            n_fail++; $display("FAIL ovf_drop: got %0d, expected 2", drop_count);
        end
        n_cmp++;
        if (fifo_level !== 3'd4) begin
            n_fail++; $display("FAIL ovf_level: got %0d, expected 4", fifo_level);
        end
        chk_word("ovf_head", wsel(recs[0], 0), 1'b0);
    endtask

    // Continues from the full state left by test_overflow.
    task automatic test_full_pop_push();
        int order [5];
        order = '{1, 2, 3, 4, 7};
        bus.word_ready_i = 1'b1;
        tick();
        tick();
        tick();
        chk_word("fpp_last_beat", wsel(recs[0], 3), 1'b1);
        bus.trace_valid_i = 1'b1;
        bus.trace_data_i  = recs[7];
        tick();
        bus.trace_valid_i = 1'b0;
        n_cmp++;
        if (drop_count !== 16'd2) begin
            n_fail++; $display("FAIL fpp_drop: got %0d, expected 2", drop_count);
        end
        n_cmp++;
        if (fifo_level !== 3'd4) begin
            n_fail++; $display("FAIL fpp_level: got %0d, expected 4", fifo_level);
        end
        // Back-to-back drain: five records, twenty words, no gap.
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 4; b++) begin
                chk_word($sformatf("b2b_rec%0d_w%0d", order[i], b), wsel(recs[order[i]], b), b == 3);
                tick();
            end
        end
        chk_idle("b2b_idle");
    endtask

    task automatic test_reset_mid();
        bus.word_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.trace_valid_i = 1'b1;
            bus.trace_data_i  = recs[k];
            tick();
        end
        bus.trace_valid_i = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd3) begin
            n_fail++; $display("FAIL rm_level_before: got %0d, expected 3", fifo_level);
        end
        bus.word_ready_i = 1'b1;
        tick();
        tick();
        chk_word("rm_beat2", wsel(recs[0], 2), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.word_valid_o !== 1'b0 || bus.word_data_o !== 32'h0 || bus.word_last_o !== 1'b0 ||
            fifo_level !== 3'd0 || busy !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rm_after_reset: valid=%b data=%h last=%b level=%0d busy=%b drop=%0d, expected all 0",
                     bus.word_valid_o, bus.word_data_o, bus.word_last_o, fifo_level, busy, drop_count);
        end
        bus.trace_valid_i = 1'b1;
        bus.trace_data_i  = recs[8];
        tick();
        bus.trace_valid_i = 1'b0;
        chk_idle("rm_gap");
        tick();
        for (int b = 0; b < 4; b++) begin
            chk_word($sformatf("rm_new_w%0d", b), wsel(recs[8], b), b == 3);
            tick();
        end
        chk_idle("rm_idle");
    endtask

    task automatic test_saturation();
        bus_sat.word_ready_i = 1'b0;
        for (int k = 0; k < 25; k++) begin
            bus_sat.trace_valid_i = 1'b1;
            bus_sat.trace_data_i  = recs[k % 9];
            tick();
            if (k == 18) begin
                n_cmp++;
                if (drop_count_sat !== 4'd14) begin
                    n_fail++; $display("FAIL sat_14: got %0d, expected 14", drop_count_sat);
                end
            end
        end
        bus_sat.trace_valid_i = 1'b0;
        n_cmp++;
        if (drop_count_sat !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d, expected 15", drop_count_sat);
        end
        n_cmp++;
        if (fifo_level_sat !== 3'd4 || busy_sat !== 1'b1) begin
            n_fail++; $display("FAIL sat_level: level=%0d busy=%b, expected level=4 busy=1",
                               fifo_level_sat, busy_sat);
        end
    endtask

    initial begin
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 4; b++) begin
                recs[k][127-32*b -: 32] = 32'hA000_0000 + 32'(k) * 32'h100 + 32'(b);
            end
        end
        bus.trace_valid_i     = 1'b0;
        bus.trace_data_i      = '0;
        bus.word_ready_i      = 1'b0;
        bus_sat.trace_valid_i = 1'b0;
        bus_sat.trace_data_i  = '0;
        bus_sat.word_ready_i  = 1'b0;
        tick();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
